drum_hit_spi_tx: RTL

//  Transmit end of the drum-zone path. Buffers drum hit events (zone, hand, velocity)

---
 rtl/drum_hit_spi_tx.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/drum_hit_spi_tx.sv
// drum_hit_spi_tx: buffers drum hit events in a small FIFO and serves them to
// the MCU as 16-bit SPI mode-0 frames (FPGA is slave, MSB first).
// Optional build macro DRUM_TX_DEDUP_EN enables per-hand duplicate suppression
// over a HOLDOFF_CYCLES window.
module drum_hit_spi_tx #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_valid,
  input  logic [2:0] hit_zone,
  input  logic       hit_left,
  input  logic [7:0] hit_velocity,
  input  logic       sck,
  input  logic       cs_n,
  output logic       sdo,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 16;
  localparam int unsigned BW = 5;

  typedef struct packed {
    logic       left;
    logic [2:0] zone;
    logic [1:0] seq;
    logic [7:0] vel;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sck_sync_q, cs_sync_q;
  logic            sck_rise_c, sck_fall_c, cs_fall_c, cs_high_c;
  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      seq_q;
  logic            overflow_q;
  logic [FW-1:0]   shreg_q;
  logic            sdo_q;
  logic [BW-1:0]   bit_cnt_q;
  logic            ov_sent_q, frame_valid_q, done_seen_q;
  logic            load_c, shift_c, bit_inc_c, done_c;
  logic            hit_ok_c, dup_c, full_c, empty_c, push_c, pop_c, drop_c;
  entry_t          head_c, new_entry_c;
  logic [FW-1:0]   frame_c;

  // Two-flop synchronizers plus a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= 3'b000;
      cs_sync_q  <= 3'b111;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      cs_sync_q  <= {cs_sync_q[1:0], cs_n};
    end
  end

  assign sck_rise_c = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_c = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall_c  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high_c  = cs_sync_q[1];

  // FIFO status, frame selection and push/drop decisions
  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign empty_c     = (count_q == CW'(0));
  assign head_c      = mem_q[rd_ptr_q];
  assign frame_c     = empty_c ? {1'b0, overflow_q, 14'h0} : {1'b1, overflow_q, head_c};
  assign hit_ok_c    = hit_valid & ~hit_zone[2];
  assign pop_c       = done_c & frame_valid_q;
  assign push_c      = hit_ok_c & ~dup_c & (~full_c | pop_c);
  assign drop_c      = hit_ok_c & ~dup_c & full_c & ~pop_c;
  assign new_entry_c = '{left: hit_left, zone: hit_zone, seq: seq_q, vel: hit_velocity};

`ifdef DRUM_TX_DEDUP_EN
  localparam int unsigned HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic [HW-1:0] hold_cnt_q  [2];
  logic [2:0]    last_zone_q [2];

  assign dup_c = hit_ok_c && (hit_zone == last_zone_q[hit_left]) &&
                 (hold_cnt_q[hit_left] < HW'(HOLDOFF_CYCLES));

  // Per-hand holdoff timers restart on every pushed hit and saturate at the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < 2; h++) begin
        hold_cnt_q[h]  <= HW'(HOLDOFF_CYCLES);
        last_zone_q[h] <= 3'd0;
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (push_c && (hit_left == 1'(h))) begin
          hold_cnt_q[h]  <= HW'(0);
          last_zone_q[h] <= hit_zone;
        end else if (hold_cnt_q[h] < HW'(HOLDOFF_CYCLES)) begin
          hold_cnt_q[h] <= hold_cnt_q[h] + HW'(1);
        end
      end
    end
  end
`else
  logic unused_holdoff;

  // Without dedup every valid hit is a candidate; the holdoff window is inert
  assign dup_c          = 1'b0;
  assign unused_holdoff = ^32'(HOLDOFF_CYCLES);
`endif

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state and datapath strobes
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    bit_inc_c = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall_c) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cs_high_c) begin
          state_d = S_IDLE;
        end else begin
          load_c  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cs_high_c) begin
          state_d = S_IDLE;
        end else begin
          shift_c   = sck_fall_c;
          bit_inc_c = sck_rise_c;
          if (sck_rise_c && (bit_cnt_q == BW'(15))) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c = ~done_seen_q;
        if (cs_high_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register, sdo and per-frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q       <= '0;
      sdo_q         <= 1'b0;
      bit_cnt_q     <= '0;
      ov_sent_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      done_seen_q   <= 1'b0;
    end else begin
      if (load_c) begin
        shreg_q       <= frame_c;
        sdo_q         <= frame_c[FW-1];
        bit_cnt_q     <= '0;
        ov_sent_q     <= overflow_q;
        frame_valid_q <= ~empty_c;
        done_seen_q   <= 1'b0;
      end
      if (shift_c) begin
        shreg_q <= {shreg_q[FW-2:0], 1'b0};
        sdo_q   <= shreg_q[FW-2];
      end
      if (bit_inc_c) bit_cnt_q <= bit_cnt_q + BW'(1);
      if (done_c) done_seen_q <= 1'b1;
    end
  end

  // FIFO pointers, occupancy, sequence number and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + 2'd1;
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_c && !pop_c) begin
        count_q <= count_q + CW'(1);
      end else if (pop_c && !push_c) begin
        count_q <= count_q - CW'(1);
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (done_c && ov_sent_q) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Event storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= new_entry_c;
  end

  assign sdo        = sdo_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
